// File: rtl/gpr_file_sb_if.sv
// Register-file bus: writeback, two read ports, destination reservation and busy flags.
interface gpr_file_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr_a;
  logic [DATA_W-1:0] rdata_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_b;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              busy_a;
  logic              busy_b;
  logic              busy_any;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b, rsv_en, rsv_addr,
    input  rdata_a, rdata_b, busy_a, busy_b, busy_any
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b, rsv_en, rsv_addr,
    output rdata_a, rdata_b, busy_a, busy_b, busy_any
  );
endinterface

// File: rtl/gpr_file_sb.sv
// Parametrised GPR file with write-to-read bypass, optional registered read
// and a per-register busy scoreboard for pending writebacks.
module gpr_file_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          READ_REG = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  gpr_file_sb_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [DATA_W-1:0] rd_a_c;
  logic [DATA_W-1:0] rd_b_c;
  logic              wr_ok_c;

  assign wr_ok_c = bus.we && !(ZERO_REG && (bus.waddr == '0));

  // Register array; a write pending in a reset cycle is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else if (wr_ok_c) begin
      regs_q[bus.waddr] <= bus.wdata;
    end
  end

  // Read port A with bypass; hardwired zero takes priority.
  always_comb begin
    rd_a_c = regs_q[bus.raddr_a];
    if (bus.we && (bus.waddr == bus.raddr_a)) begin
      rd_a_c = bus.wdata;
    end
    if (ZERO_REG && (bus.raddr_a == '0)) begin
      rd_a_c = '0;
    end
  end

  always_comb begin
    rd_b_c = regs_q[bus.raddr_b];
    if (bus.we && (bus.waddr == bus.raddr_b)) begin
      rd_b_c = bus.wdata;
    end
    if (ZERO_REG && (bus.raddr_b == '0)) begin
      rd_b_c = '0;
    end
  end

  if (READ_REG) begin : g_rd_reg
    logic [DATA_W-1:0] rdata_a_q;
    logic [DATA_W-1:0] rdata_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_a_q <= '0;
        rdata_b_q <= '0;
      end else begin
        rdata_a_q <= rd_a_c;
        rdata_b_q <= rd_b_c;
      end
    end

    assign bus.rdata_a = rdata_a_q;
    assign bus.rdata_b = rdata_b_q;
  end else begin : g_rd_comb
    assign bus.rdata_a = rd_a_c;
    assign bus.rdata_b = rd_b_c;
  end

  // Reservation is applied after the writeback clear so a new pending write wins.
  always_comb begin
    busy_d = busy_q;
    if (bus.we) begin
      busy_d[bus.waddr] = 1'b0;
    end
    if (bus.rsv_en) begin
      busy_d[bus.rsv_addr] = 1'b1;
    end
    if (ZERO_REG) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus.busy_a   = busy_q[bus.raddr_a] & ~(bus.we & (bus.waddr == bus.raddr_a));
  assign bus.busy_b   = busy_q[bus.raddr_b] & ~(bus.we & (bus.waddr == bus.raddr_b));
  assign bus.busy_any = |busy_q;

endmodule
